picosoc_sd_spi_engine: RTL and testbench
========================================

PICOSOC_SD_SPI_ENGINE -- requirements
Module: picosoc_sd_spi_engine

Interface
REQ-001 Parameter CLOCK_FREQ_HZ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter INIT_SCK_HZ, default 400000, SCK rate after reset (SD identification mode).
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port ctrl_wr  input  1  register write request, level, may stay high while a request is pending.
REQ-006 Port ctrl_rd  input  1  register read request, level, may stay high while a request is pending.
REQ-007 Port ctrl_addr  input  8  byte address: 0x00 DATA, 0x04 CTRL, 0x08 STATUS.
REQ-008 Port ctrl_wdat  input  32  write data.
REQ-009 Port ctrl_rdat  output  32  read data, valid while ctrl_done is high.
REQ-010 Port ctrl_done  output  1  one-cycle completion pulse per accepted request.
REQ-011 Port mosi  output  1  SPI data to card.
REQ-012 Port miso  input  1  SPI data from card.
REQ-013 Port sclk  output  1  SPI clock, mode 0.
REQ-014 Port cs_n  output  1  card chip select, active low.

Function
REQ-015 States IDLE, SHIFT, DONE; requests are sampled only in IDLE.
REQ-016 Request priority when both are high in IDLE: ctrl_wr over ctrl_rd.
REQ-017 IDLE + ctrl_wr to DATA: load ctrl_wdat[7:0] into tx shift register, set mosi = bit 7, clear half-period counter, go to SHIFT.
REQ-018 IDLE + any other request (CTRL/STATUS write, any read, unmapped address): go to DONE next edge.
REQ-019 Half-period = div+1 clk cycles, div = CTRL[15:8].
REQ-020 SHIFT generates 16 half-periods, sclk starting low.
REQ-021 Each rising sclk edge samples miso into rx shift register LSB, MSB first.
REQ-022 Each falling sclk edge except the last presents the next tx bit on mosi.
REQ-023 After the 16th half-period: sclk = 0, mosi = 1, rx_byte is latched, rx_valid is set, and the engine enters DONE.
REQ-024 Total latency from the DATA-write acceptance edge to ctrl_done high is 16*(div+1)+1 cycles.
REQ-025 DONE asserts ctrl_done for exactly one cycle, ignores ctrl_wr/ctrl_rd, then returns to IDLE.
REQ-026 Rationale for REQ-025: the bus-side wrapper holds its request one cycle past done, so a request seen in DONE must not start a second transfer.
REQ-027 ctrl_rdat in DONE: DATA = {24'b0, rx_byte}.
REQ-028 ctrl_rdat in DONE: CTRL = {16'b0, div, 7'b0, cs_en}.
REQ-029 ctrl_rdat in DONE: STATUS = {30'b0, cs_en, rx_valid}.
REQ-030 ctrl_rdat in DONE: unmapped address = 0.
REQ-031 ctrl_rdat is 0 outside DONE.
REQ-032 A DATA read clears rx_valid in DONE.
REQ-033 A CTRL write updates cs_en = wdat[0] and div = wdat[15:8] in DONE.
REQ-034 Writes to STATUS and unmapped addresses are ignored but still complete.
REQ-035 cs_n = !cs_en, combinational from a register; cs_n is never changed by SHIFT.
REQ-036 Outside SHIFT: sclk = 0, mosi = 1.
REQ-037 Reset value of div = min(255, max(0, CLOCK_FREQ_HZ/(2*INIT_SCK_HZ) - 1)), computed at elaboration.

Reset
REQ-038 On reset assertion, immediately and asynchronously: state IDLE, sclk 0, mosi 1, cs_n 1, ctrl_done 0, ctrl_rdat 0, rx_byte 0x00, rx_valid 0, cs_en 0, div at its reset value.
REQ-039 Reset mid-SHIFT aborts the transfer; no ctrl_done is issued for it and no partial rx_byte is kept.
REQ-040 After reset deasserts, the first edge samples requests normally.

Verification
REQ-041 Reset, STATUS read -> ctrl_done on 2nd cycle after acceptance, rdat 0x00000000, cs_n 1, sclk 0.
REQ-042 CTRL write 0x00000101, then CTRL read -> rdat 0x00000101, cs_n 0.
REQ-043 With div 1, DATA write 0xA5 and miso looped to mosi -> 8 sclk pulses of 4 cycles each, mosi bits 1,0,1,0,0,1,0,1, done 33 cycles after acceptance; DATA read returns 0x000000A5 and clears STATUS bit0.
REQ-044 Hold ctrl_wr high through DONE and one cycle after -> exactly one transfer and one ctrl_done pulse.
REQ-045 Assert reset at the 5th sclk rising edge -> sclk 0, mosi 1, cs_n 1 at once; no ctrl_done; DATA read after reset returns 0x00000000.
REQ-046 ctrl_wr and ctrl_rd both high to DATA -> a transfer starts (write wins); read of unmapped address 0x0C -> rdat 0.

Source files
------------

// File: rtl/picosoc_sd_spi_engine_if.sv
// Register-bus and SPI pin bundle for the SD-card SPI engine.
//   ctrl_wr/ctrl_rd   level requests, held until ctrl_done
//   ctrl_addr         byte address (0x00 DATA, 0x04 CTRL, 0x08 STATUS)
//   ctrl_wdat         write data
//   ctrl_rdat         read data, valid while ctrl_done is high
//   ctrl_done         one-cycle completion pulse
//   mosi/miso/sclk    SPI mode 0 pins, cs_n active-low card select
// The slave modport is the engine side; master is the bus wrapper plus card.
interface picosoc_sd_spi_engine_if;
    logic        ctrl_wr;
    logic        ctrl_rd;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;
    logic        mosi;
    logic        miso;
    logic        sclk;
    logic        cs_n;

    modport slave (
        input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat, miso,
        output ctrl_rdat, ctrl_done, mosi, sclk, cs_n
    );

    modport master (
        output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat, miso,
        input  ctrl_rdat, ctrl_done, mosi, sclk, cs_n
    );
endinterface

// File: rtl/picosoc_sd_spi_engine.sv
// SD-card SPI byte engine with a small register bus.
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    picosoc_sd_spi_engine_if.slave: register requests/response and
//          the SPI pins (mosi, miso, sclk, cs_n)
// A DATA write shifts one byte out on mosi while capturing one byte from
// miso (mode 0, MSB first); every other request completes without touching
// the SPI pins. Each sclk half-period lasts div+1 clk cycles.
module picosoc_sd_spi_engine #(
    parameter int CLOCK_FREQ_HZ = 27000000,
    parameter int INIT_SCK_HZ   = 400000
) (
    input  logic                        clk,
    input  logic                        reset,
    picosoc_sd_spi_engine_if.slave      bus
);
    // Identification-mode divider, clamped into the 8-bit field.
    localparam int         DIV_RAW = CLOCK_FREQ_HZ / (2 * INIT_SCK_HZ) - 1;
    localparam logic [7:0] DIV_RST = (DIV_RAW > 255) ? 8'd255 :
                                     (DIV_RAW < 0)   ? 8'd0   : 8'(DIV_RAW);

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_CTRL = 8'h04;
    localparam logic [7:0] ADDR_STAT = 8'h08;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [7:0]  div;
    logic        cs_en;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic [7:0]  cnt;       // clk cycles within the current half-period
    logic [3:0]  hcnt;      // half-period index 0..15
    logic        sclk_q;
    logic        mosi_q;
    logic        done_q;
    logic [31:0] rdat_q;

    // Request captured at acceptance so DONE never looks at the live bus.
    logic        req_wr;
    logic [7:0]  req_addr;
    logic        req_cs;
    logic [7:0]  req_div;

    logic [31:0] rd_mux;
    logic [15:0] unused_wdat;

    assign unused_wdat   = bus.ctrl_wdat[31:16];

    assign bus.sclk      = sclk_q;
    assign bus.mosi      = mosi_q;
    assign bus.cs_n      = ~cs_en;
    assign bus.ctrl_done = done_q;
    assign bus.ctrl_rdat = rdat_q;

    always_comb begin
        rd_mux = '0;
        case (req_addr)
            ADDR_DATA: rd_mux = {24'h0, rx_byte};
            ADDR_CTRL: rd_mux = {16'h0, div, 7'h0, cs_en};
            ADDR_STAT: rd_mux = {30'h0, cs_en, rx_valid};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div      <= DIV_RST;
            cs_en    <= 1'b0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
            cnt      <= 8'h00;
            hcnt     <= 4'h0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            done_q   <= 1'b0;
            rdat_q   <= '0;
            req_wr   <= 1'b0;
            req_addr <= 8'h00;
            req_cs   <= 1'b0;
            req_div  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ctrl_wr || bus.ctrl_rd) begin
                        // Write wins when both are raised together.
                        req_wr   <= bus.ctrl_wr;
                        req_addr <= bus.ctrl_addr;
                        req_cs   <= bus.ctrl_wdat[0];
                        req_div  <= bus.ctrl_wdat[15:8];
                        if (bus.ctrl_wr && bus.ctrl_addr == ADDR_DATA) begin
                            tx_sr  <= bus.ctrl_wdat[7:0];
                            mosi_q <= bus.ctrl_wdat[7];
                            cnt    <= 8'h00;
                            hcnt   <= 4'h0;
                            state  <= SHIFT;
                        end else begin
                            state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt == div) begin
                        cnt  <= 8'h00;
                        hcnt <= hcnt + 4'd1;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_sr  <= {rx_sr[6:0], bus.miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (hcnt == 4'd15) begin
                                mosi_q   <= 1'b1;
                                rx_byte  <= rx_sr;
                                rx_valid <= 1'b1;
                                state    <= DONE;
                            end else begin
                                mosi_q <= tx_sr[6];
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle raises done and applies side effects;
                    // the second drops done and returns to IDLE. A request
                    // still held here is never re-sampled.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        rdat_q <= rd_mux;
                        if (req_wr && req_addr == ADDR_CTRL) begin
                            cs_en <= req_cs;
                            div   <= req_div;
                        end
                        if (!req_wr && req_addr == ADDR_DATA)
                            rx_valid <= 1'b0;
                    end else begin
                        done_q <= 1'b0;
                        rdat_q <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_picosoc_sd_spi_engine.sv
module tb_picosoc_sd_spi_engine;
    logic clk;
    logic reset;

    picosoc_sd_spi_engine_if bus ();

    picosoc_sd_spi_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset divider from the identification-rate formula.
    localparam int RST_DIV_I = 27000000 / (2 * 400000) - 1;
    localparam logic [7:0] RST_DIV = (RST_DIV_I > 255) ? 8'd255 :
                                     (RST_DIV_I < 0) ? 8'd0 : 8'(RST_DIV_I);

    int n_chk  = 0;
    int n_fail = 0;

    // Reference register state.
    logic [7:0] m_div   = RST_DIV;
    logic       m_cs    = 1'b0;
    logic [7:0] m_rx    = 8'h00;
    logic       m_valid = 1'b0;

    // Card and pin observers.
    bit         loopback = 1'b0;
    logic [7:0] card_sr  = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    int         pulses   = 0;
    int         hi_cnt   = 0;
    int         done_cnt = 0;

    assign bus.miso = loopback ? bus.mosi : card_sr[7];

    always @(negedge bus.sclk) card_sr = {card_sr[6:0], 1'b0};
    always @(posedge bus.sclk) begin
        mosi_cap = {mosi_cap[6:0], bus.mosi};
        pulses   = pulses + 1;
    end
    always @(negedge clk) begin
        if (bus.sclk)      hi_cnt   = hi_cnt + 1;
        if (bus.ctrl_done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [7:0] a);
        case (a)
            8'h00:   return {24'h0, m_rx};
            8'h04:   return {16'h0, m_div, 7'h0, m_cs};
            8'h08:   return {30'h0, m_cs, m_valid};
            default: return 32'h0;
        endcase
    endfunction

    // Called #1 after a posedge with the engine idle. Holds the request
    // through the cycle in which done is seen and one edge beyond it.
    task automatic do_req(input bit wr, input bit rd, input logic [7:0] addr,
                          input logic [31:0] wdat, output logic [31:0] rdat,
                          output int lat, output bit ok, output logic post_done,
                          output logic [31:0] post_rdat);
        bus.ctrl_wr   = wr;
        bus.ctrl_rd   = rd;
        bus.ctrl_addr = addr;
        bus.ctrl_wdat = wdat;
        @(posedge clk);
        lat = 0;
        ok  = 1'b0;
        while (lat < 6000 && !ok) begin
            @(posedge clk); #1;
            lat++;
            if (bus.ctrl_done) ok = 1'b1;
        end
        rdat = bus.ctrl_rdat;
        @(posedge clk); #1;
        post_done   = bus.ctrl_done;
        post_rdat   = bus.ctrl_rdat;
        bus.ctrl_wr = 1'b0;
        bus.ctrl_rd = 1'b0;
    endtask

    task automatic op(input bit wr, input bit rd, input logic [7:0] addr, input logic [31:0] wdat);
        logic [31:0] exp_rd, got_rd, post_rd;
        logic [7:0]  rxb;
        logic        post_done;
        int          lat, exp_lat, exp_hi, d0;
        bit          ok, xfer;
        xfer     = wr && (addr == 8'h00);
        rxb      = loopback ? wdat[7:0] : 8'($urandom);
        card_sr  = rxb;
        pulses   = 0;
        hi_cnt   = 0;
        d0       = done_cnt;
        exp_lat  = xfer ? 16 * (int'(m_div) + 1) + 1 : 1;
        exp_hi   = 8 * (int'(m_div) + 1);
        exp_rd   = xfer ? {24'h0, rxb} : mread(addr);
        do_req(wr, rd, addr, wdat, got_rd, lat, ok, post_done, post_rd);
        chk("timeout", 32'(ok), 32'd1);
        chk("latency", lat, exp_lat);
        if (xfer || !wr) chk("rdat", got_rd, exp_rd);
        chk("done_width", 32'(post_done), 32'd0);
        chk("rdat_idle", post_rd, 32'h0);
        if (xfer) begin
            m_rx    = rxb;
            m_valid = 1'b1;
            chk("mosi_bits", 32'(mosi_cap), 32'(wdat[7:0]));
            chk("sclk_high", hi_cnt, exp_hi);
        end else if (wr && addr == 8'h04) begin
            m_cs  = wdat[0];
            m_div = wdat[15:8];
        end else if (!wr && addr == 8'h00) begin
            m_valid = 1'b0;
        end
        chk("pulses", pulses, xfer ? 8 : 0);
        repeat (2) @(posedge clk);
        #1;
        chk("one_done", done_cnt - d0, 1);
        chk("idle_pins", {29'h0, bus.sclk, bus.mosi, bus.cs_n}, {29'h0, 1'b0, 1'b1, ~m_cs});
    endtask

    initial begin
        bit ok;
        int d0;
        logic [7:0]  a;
        logic [31:0] w;
        bit wr, rd;

        reset         = 1'b1;
        bus.ctrl_wr   = 1'b0;
        bus.ctrl_rd   = 1'b0;
        bus.ctrl_addr = 8'h00;
        bus.ctrl_wdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(bus.ctrl_done), 32'd0);
        chk("rst_rdat", bus.ctrl_rdat, 32'h0);
        chk("rst_pins", {29'h0, bus.sclk, bus.mosi, bus.cs_n}, 32'b011);
        reset = 1'b0;

        // Status after reset, then chip-select/divider programming.
        op(1'b0, 1'b1, 8'h08, 32'h0);
        op(1'b0, 1'b1, 8'h04, 32'h0);
        op(1'b1, 1'b0, 8'h04, 32'h0000_0101);
        op(1'b0, 1'b1, 8'h04, 32'h0);

        // Loopback 0xA5 at div 1; data read clears the valid flag.
        loopback = 1'b1;
        op(1'b1, 1'b0, 8'h00, 32'h0000_00A5);
        op(1'b0, 1'b1, 8'h08, 32'h0);
        op(1'b0, 1'b1, 8'h00, 32'h0);
        op(1'b0, 1'b1, 8'h08, 32'h0);

        // Write and read together on DATA: a transfer runs.
        loopback = 1'b0;
        op(1'b1, 1'b1, 8'h00, 32'h0000_003C);
        op(1'b0, 1'b1, 8'h0C, 32'h0);
        op(1'b1, 1'b0, 8'h0C, 32'hFFFF_FFFF);
        op(1'b1, 1'b0, 8'h08, 32'hFFFF_FFFF);
        op(1'b0, 1'b1, 8'h04, 32'h0);

        for (int i = 0; i < 40; i++) begin
            wr = ($urandom_range(0, 9) < 5);
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            case ($urandom_range(0, 4))
                0:       a = 8'h00;
                1:       a = 8'h04;
                2:       a = 8'h08;
                3:       a = 8'($urandom);
                default: a = 8'h00;
            endcase
            w        = $urandom;
            w[15:8]  = 8'($urandom_range(0, 5));
            loopback = 1'($urandom_range(0, 1));
            op(wr, rd, a, w);
        end

        // Abort a transfer with reset at the 5th rising sclk.
        loopback = 1'b0;
        op(1'b1, 1'b0, 8'h04, 32'h0000_0201);
        card_sr       = 8'hC3;
        pulses        = 0;
        d0            = done_cnt;
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_addr = 8'h00;
        bus.ctrl_wdat = 32'h0000_005A;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk); #1;
            if (pulses == 5) ok = 1'b1;
        end
        chk("sclk5_seen", 32'(ok), 32'd1);
        reset       = 1'b1;
        bus.ctrl_wr = 1'b0;
        #1;
        chk("abort_pins", {29'h0, bus.sclk, bus.mosi, bus.cs_n}, 32'b011);
        chk("abort_done", 32'(bus.ctrl_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_div   = RST_DIV;
        m_cs    = 1'b0;
        m_rx    = 8'h00;
        m_valid = 1'b0;
        chk("abort_no_done", done_cnt - d0, 0);
        op(1'b0, 1'b1, 8'h00, 32'h0);
        op(1'b0, 1'b1, 8'h08, 32'h0);
        op(1'b0, 1'b1, 8'h04, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
